// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module : pc_seq_pkg
// Brief  : Shared branch-class codes and sequencer state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

    localparam logic [2:0] BR_SEQ  = 3'd0;
    localparam logic [2:0] BR_BLT  = 3'd1;
    localparam logic [2:0] BR_BEQ  = 3'd2;
    localparam logic [2:0] BR_JAL  = 3'd3;
    localparam logic [2:0] BR_JALR = 3'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

endpackage : pc_seq_pkg

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Saturating up-counter for performance-debug event counts.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             ClockIn,
    input  logic             ResetNIn,
    input  logic             IncIn,
    output logic [CNT_W-1:0] CountOut
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge ClockIn or negedge ResetNIn) begin
        if (!ResetNIn) begin
            r_count <= '0;
        end else if (IncIn && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign CountOut = r_count;

endmodule : sat_counter

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module : pc_sequencer
// Brief  : Program counter, branch resolution, flush generation, boot/halt FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] TRAP_VEC  = 32'h0000_0100,
    parameter int              BOOT_CYCLES = 2,
    parameter int              CNT_W       = 16
) (
    input  logic              ClockIn,
    input  logic              ResetNIn,
    input  logic [2:0]        BranchTypeIn,
    input  logic              LessIn,
    input  logic              ZeroIn,
    input  logic [ADDR_W-1:0] RegRelAddrIn,
    input  logic [ADDR_W-1:0] PCRelAddrIn,
    input  logic              StallIn,
    input  logic              HaltIn,
    output logic [ADDR_W-1:0] PCOut,
    output logic [ADDR_W-1:0] SeqAddrOut,
    output logic              FlushIFIDOut,
    output logic              FlushIDEXOut,
    output logic              TakenOut,
    output logic              HaltedOut,
    output logic [CNT_W-1:0]  RedirectCntOut
);

    localparam int                c_BOOT_W    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [c_BOOT_W-1:0] c_BOOT_INIT = c_BOOT_W'(BOOT_CYCLES - 1);

    state_t              r_state;
    state_t              w_stateNext;
    logic [c_BOOT_W-1:0] r_bootCnt;
    logic [c_BOOT_W-1:0] w_bootCntNext;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pcNext;
    logic [ADDR_W-1:0]   w_target;
    logic                w_brHit;
    logic                w_taken;
    logic                w_flushIfId;
    logic                w_flushIdEx;
    logic                w_halted;

    // Branch resolution is state-independent; the FSM decides whether to act on it.
    always_comb begin
        w_brHit  = 1'b0;
        w_target = PCRelAddrIn;
        case (BranchTypeIn)
            BR_SEQ:  w_brHit = 1'b0;
            BR_BLT:  w_brHit = LessIn;
            BR_BEQ:  w_brHit = ZeroIn;
            BR_JAL:  w_brHit = 1'b1;
            BR_JALR: begin
                w_brHit  = 1'b1;
                w_target = RegRelAddrIn;
            end
            default: begin
                w_brHit  = 1'b1;
                w_target = TRAP_VEC;
            end
        endcase
    end

    always_ff @(posedge ClockIn or negedge ResetNIn) begin
        if (!ResetNIn) begin
            r_state   <= ST_BOOT;
            r_bootCnt <= c_BOOT_INIT;
            r_pc      <= RESET_VEC;
        end else begin
            r_state   <= w_stateNext;
            r_bootCnt <= w_bootCntNext;
            r_pc      <= w_pcNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_bootCntNext = r_bootCnt;
        w_pcNext      = r_pc;
        w_taken       = 1'b0;
        w_flushIfId   = 1'b0;
        w_flushIdEx   = 1'b0;
        w_halted      = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_flushIfId = 1'b1;
                w_flushIdEx = 1'b1;
                if (r_bootCnt == '0) begin
                    w_stateNext = ST_RUN;
                end else begin
                    w_bootCntNext = r_bootCnt - c_BOOT_W'(1);
                end
            end
            ST_RUN: begin
                if (w_brHit) begin
                    w_taken     = 1'b1;
                    w_flushIfId = 1'b1;
                    w_flushIdEx = 1'b1;
                    w_pcNext    = w_target;
                end else if (StallIn) begin
                    // ID/EX bubble for a load-use stall comes from the hazard unit.
                    w_pcNext = r_pc;
                end else if (HaltIn) begin
                    w_stateNext = ST_HALT;
                    w_flushIfId = 1'b1;
                end else begin
                    w_pcNext = SeqAddrOut;
                end
            end
            ST_HALT: begin
                w_halted    = 1'b1;
                w_flushIfId = 1'b1;
            end
            default: begin
                w_stateNext = ST_BOOT;
            end
        endcase
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_redirectCnt (
        .ClockIn  (ClockIn),
        .ResetNIn (ResetNIn),
        .IncIn    (w_taken),
        .CountOut (RedirectCntOut)
    );

    // Reset holds the FSM in BOOT, so strobes are masked to stay quiet while ResetNIn is low.
    assign PCOut        = r_pc;
    assign SeqAddrOut   = r_pc + ADDR_W'(1);
    assign FlushIFIDOut = w_flushIfId & ResetNIn;
    assign FlushIDEXOut = w_flushIdEx & ResetNIn;
    assign TakenOut     = w_taken & ResetNIn;
    assign HaltedOut    = w_halted & ResetNIn;

endmodule : pc_sequencer

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module : tb_pc_sequencer
// Brief  : Directed self-checking bench for pc_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clk;
    logic        ResetNIn;
    logic [2:0]  BranchTypeIn;
    logic        LessIn;
    logic        ZeroIn;
    logic [31:0] RegRelAddrIn;
    logic [31:0] PCRelAddrIn;
    logic        StallIn;
    logic        HaltIn;

    logic [31:0] PCOut, SeqAddrOut;
    logic        FlushIFIDOut, FlushIDEXOut, TakenOut, HaltedOut;
    logic [15:0] RedirectCntOut;

    logic [31:0] sPCOut, sSeqAddrOut;
    logic        sFlushIFIDOut, sFlushIDEXOut, sTakenOut, sHaltedOut;
    logic [1:0]  sRedirectCntOut;

    int nChecks = 0;
    int nFails  = 0;

    pc_sequencer dut (
        .ClockIn        (clk),
        .ResetNIn       (ResetNIn),
        .BranchTypeIn   (BranchTypeIn),
        .LessIn         (LessIn),
        .ZeroIn         (ZeroIn),
        .RegRelAddrIn   (RegRelAddrIn),
        .PCRelAddrIn    (PCRelAddrIn),
        .StallIn        (StallIn),
        .HaltIn         (HaltIn),
        .PCOut          (PCOut),
        .SeqAddrOut     (SeqAddrOut),
        .FlushIFIDOut   (FlushIFIDOut),
        .FlushIDEXOut   (FlushIDEXOut),
        .TakenOut       (TakenOut),
        .HaltedOut      (HaltedOut),
        .RedirectCntOut (RedirectCntOut)
    );

    pc_sequencer #(.CNT_W(2)) dutSmall (
        .ClockIn        (clk),
        .ResetNIn       (ResetNIn),
        .BranchTypeIn   (BranchTypeIn),
        .LessIn         (LessIn),
        .ZeroIn         (ZeroIn),
        .RegRelAddrIn   (RegRelAddrIn),
        .PCRelAddrIn    (PCRelAddrIn),
        .StallIn        (StallIn),
        .HaltIn         (HaltIn),
        .PCOut          (sPCOut),
        .SeqAddrOut     (sSeqAddrOut),
        .FlushIFIDOut   (sFlushIFIDOut),
        .FlushIDEXOut   (sFlushIDEXOut),
        .TakenOut       (sTakenOut),
        .HaltedOut      (sHaltedOut),
        .RedirectCntOut (sRedirectCntOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        BranchTypeIn = 3'd0; LessIn = 1'b0; ZeroIn = 1'b0;
        RegRelAddrIn = 32'h0; PCRelAddrIn = 32'h0;
        StallIn = 1'b0; HaltIn = 1'b0;
    endtask

    // Pulses reset and returns at the first RUN-state negedge with PC at 0.
    task automatic do_reset();
        @(negedge clk);
        ResetNIn = 1'b0;
        #1;
        ResetNIn = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        ResetNIn = 1'b0;
        #2;
        nChecks++; if (PCOut !== 32'h0) begin nFails++; $display("FAIL rst_pc: got %h expected %h", PCOut, 32'h0); end
        nChecks++; if (RedirectCntOut !== 16'h0) begin nFails++; $display("FAIL rst_cnt: got %h expected 0", RedirectCntOut); end
        nChecks++; if ({FlushIFIDOut, FlushIDEXOut, TakenOut, HaltedOut} !== 4'b0000) begin nFails++; $display("FAIL rst_strobes: got %b expected 0000", {FlushIFIDOut, FlushIDEXOut, TakenOut, HaltedOut}); end
        @(negedge clk);
        ResetNIn = 1'b1;
        #1;
        nChecks++; if ({FlushIFIDOut, FlushIDEXOut} !== 2'b11) begin nFails++; $display("FAIL boot1_flush: got %b expected 11", {FlushIFIDOut, FlushIDEXOut}); end
        @(negedge clk);
        nChecks++; if ({FlushIFIDOut, FlushIDEXOut} !== 2'b11) begin nFails++; $display("FAIL boot2_flush: got %b expected 11", {FlushIFIDOut, FlushIDEXOut}); end
        nChecks++; if (PCOut !== 32'h0) begin nFails++; $display("FAIL boot2_pc: got %h expected 0", PCOut); end
        @(negedge clk);
        nChecks++; if ({FlushIFIDOut, FlushIDEXOut} !== 2'b00) begin nFails++; $display("FAIL run_flush: got %b expected 00", {FlushIFIDOut, FlushIDEXOut}); end
        nChecks++; if (PCOut !== 32'h0) begin nFails++; $display("FAIL run_pc0: got %h expected 0", PCOut); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            nChecks++; if (PCOut !== 32'(i)) begin nFails++; $display("FAIL seq_pc%0d: got %h expected %h", i, PCOut, 32'(i)); end
        end
    endtask

    task automatic test_cond_branch();
        @(negedge clk);
        @(negedge clk);
        nChecks++; if (PCOut !== 32'h5) begin nFails++; $display("FAIL pc5: got %h expected 5", PCOut); end
        BranchTypeIn = 3'd2; ZeroIn = 1'b1; PCRelAddrIn = 32'h40;
        #1;
        nChecks++; if ({TakenOut, FlushIFIDOut, FlushIDEXOut} !== 3'b111) begin nFails++; $display("FAIL beq_taken: got %b expected 111", {TakenOut, FlushIFIDOut, FlushIDEXOut}); end
        @(negedge clk);
        nChecks++; if (PCOut !== 32'h40) begin nFails++; $display("FAIL beq_pc: got %h expected 40", PCOut); end
        nChecks++; if (RedirectCntOut !== 16'd1) begin nFails++; $display("FAIL beq_cnt: got %0d expected 1", RedirectCntOut); end
        ZeroIn = 1'b0; PCRelAddrIn = 32'h80;
        #1;
        nChecks++; if ({TakenOut, FlushIFIDOut, FlushIDEXOut} !== 3'b000) begin nFails++; $display("FAIL beq_nt: got %b expected 000", {TakenOut, FlushIFIDOut, FlushIDEXOut}); end
        @(negedge clk);
        nChecks++; if (PCOut !== 32'h41) begin nFails++; $display("FAIL beq_nt_pc: got %h expected 41", PCOut); end
        BranchTypeIn = 3'd1; LessIn = 1'b1; PCRelAddrIn = 32'h50;
        @(negedge clk);
        nChecks++; if (PCOut !== 32'h50) begin nFails++; $display("FAIL blt_pc: got %h expected 50", PCOut); end
        nChecks++; if (RedirectCntOut !== 16'd2) begin nFails++; $display("FAIL blt_cnt: got %0d expected 2", RedirectCntOut); end
        idle();
    endtask

    task automatic test_jalr_stall();
        BranchTypeIn = 3'd4; RegRelAddrIn = 32'h1234; PCRelAddrIn = 32'h999; StallIn = 1'b1;
        #1;
        nChecks++; if (TakenOut !== 1'b1) begin nFails++; $display("FAIL jalr_taken: got %b expected 1", TakenOut); end
        @(negedge clk);
        nChecks++; if (PCOut !== 32'h1234) begin nFails++; $display("FAIL jalr_pc: got %h expected 1234", PCOut); end
        idle();
        @(negedge clk);
        nChecks++; if (PCOut !== 32'h1235) begin nFails++; $display("FAIL post_jalr_pc: got %h expected 1235", PCOut); end
        StallIn = 1'b1;
        #1;
        nChecks++; if ({TakenOut, FlushIFIDOut, FlushIDEXOut} !== 3'b000) begin nFails++; $display("FAIL stall_strobes: got %b expected 000", {TakenOut, FlushIFIDOut, FlushIDEXOut}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nChecks++; if (PCOut !== 32'h1235) begin nFails++; $display("FAIL stall_hold%0d: got %h expected 1235", i, PCOut); end
        end
        StallIn = 1'b0;
        @(negedge clk);
        nChecks++; if (PCOut !== 32'h1236) begin nFails++; $display("FAIL stall_release: got %h expected 1236", PCOut); end
        nChecks++; if (RedirectCntOut !== 16'd3) begin nFails++; $display("FAIL jalr_cnt: got %0d expected 3", RedirectCntOut); end
    endtask

    task automatic test_trap_halt();
        BranchTypeIn = 3'd6;
        #1;
        nChecks++; if (TakenOut !== 1'b1) begin nFails++; $display("FAIL trap_taken: got %b expected 1", TakenOut); end
        @(negedge clk);
        nChecks++; if (PCOut !== 32'h100) begin nFails++; $display("FAIL trap_pc: got %h expected 100", PCOut); end
        idle();
        @(negedge clk);
        nChecks++; if (PCOut !== 32'h101) begin nFails++; $display("FAIL trap_seq: got %h expected 101", PCOut); end
        HaltIn = 1'b1;
        #1;
        nChecks++; if ({HaltedOut, FlushIFIDOut, FlushIDEXOut} !== 3'b010) begin nFails++; $display("FAIL halt_req: got %b expected 010", {HaltedOut, FlushIFIDOut, FlushIDEXOut}); end
        @(negedge clk);
        BranchTypeIn = 3'd3; PCRelAddrIn = 32'h300;
        for (int i = 0; i < 10; i++) begin
            StallIn = i[0];
            #1;
            nChecks++; if (PCOut !== 32'h101) begin nFails++; $display("FAIL halt_pc%0d: got %h expected 101", i, PCOut); end
            nChecks++; if ({HaltedOut, TakenOut, FlushIFIDOut, FlushIDEXOut} !== 4'b1010) begin nFails++; $display("FAIL halt_strobes%0d: got %b expected 1010", i, {HaltedOut, TakenOut, FlushIFIDOut, FlushIDEXOut}); end
            @(negedge clk);
        end
        nChecks++; if (RedirectCntOut !== 16'd4) begin nFails++; $display("FAIL halt_cnt: got %0d expected 4", RedirectCntOut); end
        idle();
    endtask

    task automatic test_wrap();
        do_reset();
        BranchTypeIn = 3'd4; RegRelAddrIn = 32'hFFFF_FFFF;
        @(negedge clk);
        nChecks++; if (PCOut !== 32'hFFFF_FFFF) begin nFails++; $display("FAIL wrap_pc: got %h expected ffffffff", PCOut); end
        nChecks++; if (SeqAddrOut !== 32'h0) begin nFails++; $display("FAIL wrap_seq: got %h expected 0", SeqAddrOut); end
        idle();
        @(negedge clk);
        nChecks++; if (PCOut !== 32'h0) begin nFails++; $display("FAIL wrap_next: got %h expected 0", PCOut); end
        nChecks++; if (RedirectCntOut !== 16'd1) begin nFails++; $display("FAIL wrap_cnt: got %0d expected 1", RedirectCntOut); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] expSmall;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            BranchTypeIn = 3'd3; PCRelAddrIn = 32'h10 + 32'(i);
            #1;
            nChecks++; if (TakenOut !== 1'b1) begin nFails++; $display("FAIL b2b_taken%0d: got %b expected 1", i, TakenOut); end
            @(negedge clk);
            nChecks++; if (PCOut !== 32'h10 + 32'(i)) begin nFails++; $display("FAIL b2b_pc%0d: got %h expected %h", i, PCOut, 32'h10 + 32'(i)); end
            expSmall = (i >= 2) ? 2'd3 : 2'(i + 1);
            nChecks++; if (sRedirectCntOut !== expSmall) begin nFails++; $display("FAIL sat_cnt%0d: got %0d expected %0d", i, sRedirectCntOut, expSmall); end
        end
        nChecks++; if (RedirectCntOut !== 16'd5) begin nFails++; $display("FAIL b2b_cnt: got %0d expected 5", RedirectCntOut); end
        idle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        BranchTypeIn = 3'd3; PCRelAddrIn = 32'h77;
        #1;
        nChecks++; if (TakenOut !== 1'b1) begin nFails++; $display("FAIL mid_taken: got %b expected 1", TakenOut); end
        ResetNIn = 1'b0;
        #1;
        nChecks++; if (PCOut !== 32'h0) begin nFails++; $display("FAIL mid_pc: got %h expected 0", PCOut); end
        nChecks++; if (RedirectCntOut !== 16'h0) begin nFails++; $display("FAIL mid_cnt: got %0d expected 0", RedirectCntOut); end
        nChecks++; if ({FlushIFIDOut, FlushIDEXOut, TakenOut} !== 3'b000) begin nFails++; $display("FAIL mid_strobes: got %b expected 000", {FlushIFIDOut, FlushIDEXOut, TakenOut}); end
        @(negedge clk);
        nChecks++; if (PCOut !== 32'h0) begin nFails++; $display("FAIL mid_hold: got %h expected 0", PCOut); end
        ResetNIn = 1'b1;
        #1;
        nChecks++; if ({FlushIFIDOut, FlushIDEXOut, TakenOut} !== 3'b110) begin nFails++; $display("FAIL reboot1: got %b expected 110", {FlushIFIDOut, FlushIDEXOut, TakenOut}); end
        @(negedge clk);
        nChecks++; if ({FlushIFIDOut, FlushIDEXOut, TakenOut} !== 3'b110) begin nFails++; $display("FAIL reboot2: got %b expected 110", {FlushIFIDOut, FlushIDEXOut, TakenOut}); end
        idle();
        @(negedge clk);
        nChecks++; if (PCOut !== 32'h0 || FlushIFIDOut !== 1'b0) begin nFails++; $display("FAIL reboot_run: got pc %h flush %b expected 0/0", PCOut, FlushIFIDOut); end
        @(negedge clk);
        nChecks++; if (PCOut !== 32'h1) begin nFails++; $display("FAIL reboot_seq: got %h expected 1", PCOut); end
    endtask

    task automatic test_taken_beats_halt();
        BranchTypeIn = 3'd3; PCRelAddrIn = 32'h500; HaltIn = 1'b1;
        #1;
        nChecks++; if ({TakenOut, FlushIFIDOut, FlushIDEXOut} !== 3'b111) begin nFails++; $display("FAIL th_taken: got %b expected 111", {TakenOut, FlushIFIDOut, FlushIDEXOut}); end
        @(negedge clk);
        nChecks++; if (PCOut !== 32'h500 || HaltedOut !== 1'b0) begin nFails++; $display("FAIL th_pc: got pc %h halted %b expected 500/0", PCOut, HaltedOut); end
        BranchTypeIn = 3'd0;
        #1;
        nChecks++; if ({TakenOut, FlushIFIDOut, FlushIDEXOut} !== 3'b010) begin nFails++; $display("FAIL th_halt_req: got %b expected 010", {TakenOut, FlushIFIDOut, FlushIDEXOut}); end
        @(negedge clk);
        nChecks++; if (HaltedOut !== 1'b1 || PCOut !== 32'h500) begin nFails++; $display("FAIL th_halted: got halted %b pc %h expected 1/500", HaltedOut, PCOut); end
        nChecks++; if (RedirectCntOut !== 16'd1) begin nFails++; $display("FAIL th_cnt: got %0d expected 1", RedirectCntOut); end
        idle();
    endtask

    initial begin
        test_reset();
        test_cond_branch();
        test_jalr_stall();
        test_trap_halt();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_taken_beats_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule : tb_pc_sequencer

`default_nettype wire
